// File: rtl/add_sub_pkg.sv
// Shared definitions for the pipelined add/sub primitive: op encoding and
// saturation limits sized to any operand width up to MAX_WIDTH.
package add_sub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } op_e;

    localparam int MAX_WIDTH = 64;

    // Limits are returned at MAX_WIDTH and sliced to the real width by the caller.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width, input bit is_signed);
        logic [MAX_WIDTH-1:0] ones;
        ones = '1;
        sat_max = is_signed ? (ones >> (MAX_WIDTH - width + 1)) : (ones >> (MAX_WIDTH - width));
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width, input bit is_signed);
        logic [MAX_WIDTH-1:0] one;
        one = 1;
        sat_min = is_signed ? (one << (width - 1)) : '0;
    endfunction

endpackage

// File: rtl/add_sub_core.sv
// Combinational add/sub datapath: WIDTH+1 sum, carry/not-borrow, overflow, clamp.
// Zero latency; no flow control.
module add_sub_core
    import add_sub_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             sat
);

    localparam logic [MAX_WIDTH-1:0] HI_FULL = sat_max(WIDTH, SIGNED != 0);
    localparam logic [MAX_WIDTH-1:0] LO_FULL = sat_min(WIDTH, SIGNED != 0);
    localparam logic [WIDTH-1:0]     SAT_HI  = HI_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_LO  = LO_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic             x_msb;
    logic             y_msb;
    logic             r_msb;

    // Subtraction as X + ~Y + cin: the carry out of the top bit is the not-borrow.
    always_comb begin
        y_eff = sub ? ~y : y;
        sum   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin};
        raw   = sum[WIDTH-1:0];
        cout  = sum[WIDTH];
        x_msb = x[WIDTH-1];
        y_msb = y[WIDTH-1];
        r_msb = raw[WIDTH-1];

        if (SIGNED != 0) begin
            if (sub) begin
                overflow = (x_msb != y_msb) && (r_msb != x_msb);
            end else begin
                overflow = (x_msb == y_msb) && (r_msb != x_msb);
            end
        end else begin
            overflow = sub ? ~cout : cout;
        end

        sat    = (SATURATE != 0) && overflow;
        result = raw;
        if (sat) begin
            if (SIGNED != 0) begin
                result = x_msb ? SAT_LO : SAT_HI;
            end else begin
                result = sub ? SAT_LO : SAT_HI;
            end
        end
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub with running accumulator and valid/ready handshake.
// Latency PIPE_DEPTH advancing cycles; whole pipe stalls when output is held or clken low.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PIPE_DEPTH = 2,
    parameter int SIGNED     = 1,
    parameter int SATURATE   = 0
) (
    input  logic             i_clock,
    input  logic             i_aclr,
    input  logic             i_clken,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic             i_acc_clr,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_overflow,
    output logic             o_sat
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("add_sub_pipe: WIDTH out of range");
    end
    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $error("add_sub_pipe: PIPE_DEPTH must be at least 1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             overflow;
        logic             sat;
    } beat_t;

    op_e              op;
    logic             adv;
    logic             accept;
    logic             acc_op;
    logic             sub_op;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    beat_t            core_beat;
    logic [PIPE_DEPTH-1:0] vld_q;
    beat_t            dat_q [PIPE_DEPTH];

    assign op     = op_e'(i_op);
    assign acc_op = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
    assign sub_op = (op == OP_SUB) || (op == OP_ACC_SUB);

    // Bubbles travel with the pipe; nothing moves unless the output slot frees up.
    assign adv     = i_clken & (~o_valid | i_ready) & ~i_aclr;
    assign o_ready = adv;
    assign accept  = i_valid & adv;

    assign x = acc_op ? (i_acc_clr ? '0 : acc_q) : i_a;
    assign y = acc_op ? i_a : i_b;

    add_sub_core #(
        .WIDTH    (WIDTH),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_core (
        .x        (x),
        .y        (y),
        .cin      (i_cin),
        .sub      (sub_op),
        .result   (core_beat.result),
        .cout     (core_beat.cout),
        .overflow (core_beat.overflow),
        .sat      (core_beat.sat)
    );

    // ACC loads the post-clamp result alongside stage 1, so consecutive
    // accumulate beats see each other's result without a hazard.
    always_ff @(posedge i_clock or posedge i_aclr) begin
        if (i_aclr) begin
            acc_q <= '0;
            vld_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= i_valid;
            dat_q[0] <= core_beat;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            if (accept && acc_op) begin
                acc_q <= core_beat.result;
            end
        end
    end

    assign o_valid    = vld_q[PIPE_DEPTH-1];
    assign o_result   = dat_q[PIPE_DEPTH-1].result;
    assign o_cout     = dat_q[PIPE_DEPTH-1].cout;
    assign o_overflow = dat_q[PIPE_DEPTH-1].overflow;
    assign o_sat      = dat_q[PIPE_DEPTH-1].sat;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: three 8-bit configurations driven in lockstep,
// checked against an integer-arithmetic model with a latency scoreboard.
module tb_add_sub_pipe;
    import add_sub_pkg::*;

    localparam int W  = 8;
    localparam int PD = 2;

    logic       clk = 1'b0;
    logic       aclr = 1'b1;
    logic       clken = 1'b0;
    logic       valid = 1'b0;
    logic       ready = 1'b0;
    logic       acc_clr = 1'b0;
    logic       cin = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       rdy_o  [3];
    logic       vld_o  [3];
    logic [7:0] res_o  [3];
    logic       cout_o [3];
    logic       ovf_o  [3];
    logic       sat_o  [3];

    // instance 0: signed wrap, 1: signed saturate, 2: unsigned saturate
    bit cfg_sgn [3] = '{1'b1, 1'b1, 1'b0};
    bit cfg_sat [3] = '{1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(W), .PIPE_DEPTH(PD), .SIGNED(1), .SATURATE(0)) dut_sw (
        .i_clock(clk), .i_aclr(aclr), .i_clken(clken), .i_valid(valid), .o_ready(rdy_o[0]),
        .i_op(op), .i_acc_clr(acc_clr), .i_a(a), .i_b(b), .i_cin(cin),
        .o_valid(vld_o[0]), .i_ready(ready), .o_result(res_o[0]), .o_cout(cout_o[0]),
        .o_overflow(ovf_o[0]), .o_sat(sat_o[0]));

    add_sub_pipe #(.WIDTH(W), .PIPE_DEPTH(PD), .SIGNED(1), .SATURATE(1)) dut_ss (
        .i_clock(clk), .i_aclr(aclr), .i_clken(clken), .i_valid(valid), .o_ready(rdy_o[1]),
        .i_op(op), .i_acc_clr(acc_clr), .i_a(a), .i_b(b), .i_cin(cin),
        .o_valid(vld_o[1]), .i_ready(ready), .o_result(res_o[1]), .o_cout(cout_o[1]),
        .o_overflow(ovf_o[1]), .o_sat(sat_o[1]));

    add_sub_pipe #(.WIDTH(W), .PIPE_DEPTH(PD), .SIGNED(0), .SATURATE(1)) dut_us (
        .i_clock(clk), .i_aclr(aclr), .i_clken(clken), .i_valid(valid), .o_ready(rdy_o[2]),
        .i_op(op), .i_acc_clr(acc_clr), .i_a(a), .i_b(b), .i_cin(cin),
        .o_valid(vld_o[2]), .i_ready(ready), .o_result(res_o[2]), .o_cout(cout_o[2]),
        .o_overflow(ovf_o[2]), .o_sat(sat_o[2]));

    typedef struct packed {
        logic [7:0]      age;
        logic [2:0][7:0] res;
        logic [2:0]      cout;
        logic [2:0]      ovf;
        logic [2:0]      sat;
    } exp_t;

    exp_t       q [$];
    logic [7:0] acc_m [3];
    int         checks = 0;
    int         errors = 0;
    bit         accepted;
    int         ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // True mathematical result, then range test, modulo wrap or clamp.
    function automatic logic [10:0] ref_op(input bit sgn, input bit sat_en, input logic [7:0] x,
                                           input logic [7:0] y, input logic ci, input logic sub);
        int xv, yv, tv, uv, lo, hi;
        logic [31:0] t;
        logic [7:0]  r;
        logic        ov, co, sf;
        xv = int'(x);
        yv = int'(y);
        uv = sub ? (xv - yv - (ci ? 0 : 1)) : (xv + yv + (ci ? 1 : 0));
        if (sgn && x[7]) xv = xv - 256;
        if (sgn && y[7]) yv = yv - 256;
        tv = sub ? (xv - yv - (ci ? 0 : 1)) : (xv + yv + (ci ? 1 : 0));
        lo = sgn ? -128 : 0;
        hi = sgn ? 127 : 255;
        ov = (tv < lo) || (tv > hi);
        co = sub ? (uv >= 0) : (uv > 255);
        t  = tv;
        r  = t[7:0];
        sf = 1'b0;
        if (sat_en && ov) begin
            t  = (tv > hi) ? hi : lo;
            r  = t[7:0];
            sf = 1'b1;
        end
        return {sf, ov, co, r};
    endfunction

    task automatic step();
        bit          exp_v, exp_adv;
        exp_t        e;
        logic [7:0]  x, y;
        logic [10:0] r;
        @(negedge clk);
        if (aclr) begin
            q.delete();
            for (int i = 0; i < 3; i++) acc_m[i] = '0;
        end
        exp_v   = (q.size() > 0) && (q[0].age == PD);
        exp_adv = clken && !aclr && (!exp_v || ready);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("o_ready%0d", i), rdy_o[i], exp_adv);
            check($sformatf("o_valid%0d", i), vld_o[i], exp_v);
            if (exp_v) begin
                check($sformatf("result%0d", i), res_o[i], q[0].res[i]);
                check($sformatf("cout%0d", i), cout_o[i], q[0].cout[i]);
                check($sformatf("overflow%0d", i), ovf_o[i], q[0].ovf[i]);
                check($sformatf("sat%0d", i), sat_o[i], q[0].sat[i]);
            end
        end
        accepted = exp_adv && valid;
        e = '0;
        if (accepted) begin
            e.age = 8'd1;
            for (int i = 0; i < 3; i++) begin
                x = op[1] ? (acc_clr ? 8'd0 : acc_m[i]) : a;
                y = op[1] ? a : b;
                r = ref_op(cfg_sgn[i], cfg_sat[i], x, y, cin, op[0]);
                e.res[i]  = r[7:0];
                e.cout[i] = r[8];
                e.ovf[i]  = r[9];
                e.sat[i]  = r[10];
                if (op[1]) acc_m[i] = r[7:0];
            end
        end
        @(posedge clk);
        if (exp_adv) begin
            if (exp_v) void'(q.pop_front());
            for (int k = 0; k < q.size(); k++) q[k].age = q[k].age + 8'd1;
            if (accepted) q.push_back(e);
        end
        #1;
        if (ready_mode == 1) ready = ~ready;
        else if (ready_mode == 2) ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic beat(input logic [1:0] o, input logic c, input logic [7:0] aa,
                        input logic [7:0] bb, input logic ci);
        op = o; acc_clr = c; a = aa; b = bb; cin = ci; valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (accepted) return;
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic rand_beat();
        beat(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)));
    endtask

    initial begin
        repeat (2) step();
        aclr = 1'b0; clken = 1'b1; ready = 1'b1;
        step();

        // overflow, wrap and clamp corners
        beat(OP_ADD, 1'b0, 8'd100, 8'd50, 1'b0);   idle(3);
        beat(OP_SUB, 1'b0, 8'h80, 8'd1, 1'b1);     idle(3);
        beat(OP_SUB, 1'b0, 8'd10, 8'd20, 1'b1);    idle(3);
        beat(OP_ADD, 1'b0, 8'h7F, 8'd0, 1'b1);     idle(3);

        // accumulate chain with interleaved plain beats
        beat(OP_ACC_ADD, 1'b1, 8'd5, 8'd0, 1'b0);
        beat(OP_ADD, 1'b0, 8'd3, 8'd4, 1'b0);
        beat(OP_ACC_ADD, 1'b0, 8'd7, 8'd0, 1'b0);
        beat(OP_SUB, 1'b1, 8'd9, 8'd9, 1'b1);
        beat(OP_ACC_SUB, 1'b0, 8'd2, 8'd0, 1'b1);
        idle(4);

        // back-pressure with ready toggling
        ready_mode = 1;
        repeat (8) rand_beat();
        idle(20);
        ready_mode = 0; ready = 1'b1;

        // clock-enable freeze with a beat waiting at the input
        rand_beat(); rand_beat();
        op = OP_ADD; a = 8'd33; b = 8'd44; cin = 1'b0; acc_clr = 1'b0; valid = 1'b1;
        clken = 1'b0;
        repeat (3) step();
        clken = 1'b1;
        beat(OP_ADD, 1'b0, 8'd33, 8'd44, 1'b0);
        idle(5);

        // reset with beats in flight; ACC must restart from zero
        beat(OP_ACC_ADD, 1'b0, 8'd20, 8'd0, 1'b0);
        beat(OP_ACC_ADD, 1'b0, 8'd30, 8'd0, 1'b0);
        valid = 1'b0; aclr = 1'b1;
        step();
        aclr = 1'b0;
        beat(OP_ACC_ADD, 1'b0, 8'd9, 8'd0, 1'b0);
        idle(4);

        // random traffic with random stalls, enables and rare resets
        ready_mode = 2;
        for (int n = 0; n < 800; n++) begin
            valid   = ($urandom_range(0, 3) != 0);
            op      = 2'($urandom_range(0, 3));
            acc_clr = ($urandom_range(0, 7) == 0);
            a       = 8'($urandom);
            b       = 8'($urandom);
            cin     = 1'($urandom_range(0, 1));
            clken   = ($urandom_range(0, 7) != 0);
            aclr    = ($urandom_range(0, 199) == 0);
            step();
        end
        aclr = 1'b0; clken = 1'b1; ready_mode = 0; ready = 1'b1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
